sec_countdown: RTL and testbench

- Downstream consumer of the 1 us-clock tick divider. It takes the one-cycle odd-second and even-second strobes and runs a whole-second countdown timer.
- Outputs: remaining count, busy, a warning/blink phase, and a one-cycle done pulse for the control FSM (fan/appliance timer).
- Start is always aligned to the next second boundary, so every counted second is a full second.

---
 rtl/sec_countdown_if.sv | 30 +++
 rtl/sec_countdown.sv | 150 +++++++++++++++
 tb/tb_sec_countdown.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sec_countdown_if.sv
// Purpose: groups tick strobes, control requests and countdown status for sec_countdown.
// Latency: none; this is wiring only.
// Backpressure: none; every strobe is a single-cycle pulse that is consumed when it arrives.
interface sec_countdown_if #(
    parameter int CNT_W = 8
);
    logic             tick_odd;
    logic             tick_even;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] remain;
    logic             busy;
    logic             warn;
    logic             blink;
    logic             done;
    logic             seq_err;

    // Controller side: issues ticks and requests, observes status.
    modport master (
        output tick_odd, tick_even, start, abort, load_val,
        input  remain, busy, warn, blink, done, seq_err
    );

    // Timer side: consumes ticks and requests, drives status.
    modport slave (
        input  tick_odd, tick_even, start, abort, load_val,
        output remain, busy, warn, blink, done, seq_err
    );
endinterface

// File: rtl/sec_countdown.sv
// Purpose: whole-second countdown timer aligned to second strobes; SEQ_CHECK_EN adds a tick-parity checker.
// Latency: all outputs update on the clk edge after the sec_tick/start/abort cycle.
// Backpressure: none; start while busy is dropped, abort always wins.
module sec_countdown #(
    parameter int CNT_W    = 8,
    parameter int WARN_SEC = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    sec_countdown_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        WARN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WARN_V = CNT_W'(WARN_SEC);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO   = '0;

    state_t           state_q, nxt_state;
    logic [CNT_W-1:0] remain_q, nxt_remain;
    logic             blink_q, nxt_blink;
    logic             done_q, nxt_done;
    logic             busy_q, warn_q;
    logic             sec_tick;
    logic [CNT_W-1:0] dec_val;

    assign sec_tick = bus.tick_odd | bus.tick_even;
    // Guarded so remain can never wrap below zero.
    assign dec_val  = (remain_q != ZERO) ? (remain_q - ONE) : ZERO;

    // Next-state, next-count, blink and done decode; abort overrides everything.
    always_comb begin
        nxt_state  = state_q;
        nxt_remain = remain_q;
        nxt_blink  = blink_q;
        nxt_done   = 1'b0;
        if (bus.abort) begin
            nxt_state  = IDLE;
            nxt_remain = ZERO;
            nxt_blink  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    nxt_blink = 1'b0;
                    // A tick in the same cycle as start is not used for alignment.
                    if (bus.start) begin
                        if (bus.load_val != ZERO) begin
                            nxt_state  = ARM;
                            nxt_remain = bus.load_val;
                        end else begin
                            nxt_remain = ZERO;
                            nxt_done   = 1'b1;
                        end
                    end
                end
                ARM: begin
                    // First tick only aligns to the second boundary.
                    if (sec_tick) begin
                        nxt_blink = 1'b0;
                        nxt_state = (remain_q <= WARN_V) ? WARN : RUN;
                    end
                end
                RUN: begin
                    if (sec_tick && remain_q != ZERO) begin
                        nxt_remain = dec_val;
                        if (dec_val == ZERO) begin
                            nxt_state = IDLE;
                            nxt_done  = 1'b1;
                        end else if (dec_val <= WARN_V) begin
                            nxt_state = WARN;
                            nxt_blink = 1'b0;
                        end
                    end
                end
                WARN: begin
                    if (sec_tick && remain_q != ZERO) begin
                        nxt_remain = dec_val;
                        if (dec_val == ZERO) begin
                            nxt_state = IDLE;
                            nxt_done  = 1'b1;
                            nxt_blink = 1'b0;
                        end else begin
                            nxt_blink = ~blink_q;
                        end
                    end
                end
                default: begin
                    nxt_state  = IDLE;
                    nxt_remain = ZERO;
                    nxt_blink  = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; busy/warn are decoded from the next state so they line up with remain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            remain_q <= ZERO;
            blink_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            warn_q   <= 1'b0;
        end else begin
            state_q  <= nxt_state;
            remain_q <= nxt_remain;
            blink_q  <= nxt_blink;
            done_q   <= nxt_done;
            busy_q   <= (nxt_state != IDLE);
            warn_q   <= (nxt_state == WARN);
        end
    end

    assign bus.remain = remain_q;
    assign bus.busy   = busy_q;
    assign bus.warn   = warn_q;
    assign bus.blink  = blink_q;
    assign bus.done   = done_q;

`ifdef SEQ_CHECK_EN
    logic seen_q;
    logic last_odd_q;
    logic seq_err_q;

    // Parity tracker: flags repeated parity or simultaneous strobes; sticky until reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_q     <= 1'b0;
            last_odd_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else if (sec_tick) begin
            seen_q     <= 1'b1;
            last_odd_q <= bus.tick_odd;
            if ((bus.tick_odd && bus.tick_even) ||
                (seen_q && (last_odd_q == bus.tick_odd))) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    assign bus.seq_err = seq_err_q;
`else
    assign bus.seq_err = 1'b0;
`endif
endmodule

// File: tb/tb_sec_countdown.sv
// Purpose: self-checking bench for sec_countdown using a directed vector table plus hand sequences.
// Latency: outputs are sampled 1 time unit after the clk edge that follows each applied vector.
// Backpressure: none; the bench drives single-cycle strobes only.
module tb_sec_countdown;
    logic clk;
    logic reset_n;

    sec_countdown_if #(.CNT_W(8)) bus ();

    sec_countdown #(.CNT_W(8), .WARN_SEC(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tick kinds: 0 none, 1 auto-alternating, 2 odd, 3 even, 4 both
    typedef struct {
        int       gap;
        int       tk;
        bit       start;
        bit       abort;
        bit [7:0] load;
        bit [7:0] e_remain;
        bit       e_busy;
        bit       e_warn;
        bit       e_blink;
        bit       e_done;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_err;
    bit   next_odd;

`ifdef SEQ_CHECK_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic addv(input int gap, input int tk, input bit st, input bit ab, input bit [7:0] ld,
                        input bit [7:0] r, input bit b, input bit w, input bit bl, input bit d);
        vec_t v;
        v.gap = gap; v.tk = tk; v.start = st; v.abort = ab; v.load = ld;
        v.e_remain = r; v.e_busy = b; v.e_warn = w; v.e_blink = bl; v.e_done = d;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        bus.tick_odd  = 1'b0;
        bus.tick_even = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
    endtask

    task automatic set_tick(input int tk);
        case (tk)
            1: begin
                bus.tick_odd  = next_odd;
                bus.tick_even = ~next_odd;
                next_odd      = ~next_odd;
            end
            2: begin bus.tick_odd = 1'b1; bus.tick_even = 1'b0; end
            3: begin bus.tick_odd = 1'b0; bus.tick_even = 1'b1; end
            4: begin bus.tick_odd = 1'b1; bus.tick_even = 1'b1; end
            default: begin bus.tick_odd = 1'b0; bus.tick_even = 1'b0; end
        endcase
    endtask

    // Inputs change 1 unit after a rising edge; outputs are read 1 unit after the next one.
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic apply_tick(input int tk);
        set_tick(tk);
        step();
    endtask

    task automatic chk_all(input string tag, input int r, input int b, input int w, input int bl, input int d);
        chk({tag, " remain"}, int'(bus.remain), r);
        chk({tag, " busy"},   int'(bus.busy),   b);
        chk({tag, " warn"},   int'(bus.warn),   w);
        chk({tag, " blink"},  int'(bus.blink),  bl);
        chk({tag, " done"},   int'(bus.done),   d);
    endtask

    initial begin
        bit done_seen;
        n_cmp    = 0;
        n_err    = 0;
        next_odd = 1'b1;
        reset_n  = 1'b0;
        bus.load_val = 8'd0;
        idle_inputs();

        // Reset state held for a few edges.
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        chk("reset seq_err", int'(bus.seq_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #2;

        // No stimulus other than ticks: timer stays idle, no done.
        done_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_cycles(4);
            apply_tick(1);
            if (bus.done) done_seen = 1'b1;
            chk($sformatf("idle_tick%0d remain", i), int'(bus.remain), 0);
            chk($sformatf("idle_tick%0d busy", i), int'(bus.busy), 0);
        end
        chk("idle_ticks done_seen", int'(done_seen), 0);

        // Basic countdown from 5.
        addv(2,   0, 1, 0, 5,   5, 1, 0, 0, 0);
        addv(100, 1, 0, 0, 0,   5, 1, 0, 0, 0);
        addv(100, 1, 0, 0, 0,   4, 1, 0, 0, 0);
        addv(100, 1, 0, 0, 0,   3, 1, 1, 0, 0);
        addv(100, 1, 0, 0, 0,   2, 1, 1, 1, 0);
        addv(100, 1, 0, 0, 0,   1, 1, 1, 0, 0);
        addv(100, 1, 0, 0, 0,   0, 0, 0, 0, 1);
        addv(0,   0, 0, 0, 0,   0, 0, 0, 0, 0);
        // Zero load: single done pulse, never busy.
        addv(3,   0, 1, 0, 0,   0, 0, 0, 0, 1);
        addv(0,   0, 0, 0, 0,   0, 0, 0, 0, 0);
        // Abort together with a tick at remain 8.
        addv(3,   0, 1, 0, 10,  10, 1, 0, 0, 0);
        addv(5,   1, 0, 0, 0,   10, 1, 0, 0, 0);
        addv(5,   1, 0, 0, 0,   9, 1, 0, 0, 0);
        addv(5,   1, 0, 0, 0,   8, 1, 0, 0, 0);
        addv(5,   1, 0, 1, 0,   0, 0, 0, 0, 0);
        addv(0,   0, 0, 0, 0,   0, 0, 0, 0, 0);
        // Restart with 2: goes straight to warning after alignment.
        addv(3,   0, 1, 0, 2,   2, 1, 0, 0, 0);
        addv(5,   1, 0, 0, 0,   2, 1, 1, 0, 0);
        addv(5,   1, 0, 0, 0,   1, 1, 1, 1, 0);
        addv(5,   1, 0, 0, 0,   0, 0, 0, 0, 1);
        addv(0,   0, 0, 0, 0,   0, 0, 0, 0, 0);
        // Start while busy is ignored.
        addv(3,   0, 1, 0, 4,   4, 1, 0, 0, 0);
        addv(5,   1, 0, 0, 0,   4, 1, 0, 0, 0);
        addv(5,   1, 0, 0, 0,   3, 1, 1, 0, 0);
        addv(2,   0, 1, 0, 200, 3, 1, 1, 0, 0);
        addv(5,   1, 0, 0, 0,   2, 1, 1, 1, 0);
        addv(5,   1, 0, 0, 0,   1, 1, 1, 0, 0);
        addv(5,   1, 0, 0, 0,   0, 0, 0, 0, 1);
        addv(0,   0, 0, 0, 0,   0, 0, 0, 0, 0);
        // Start and tick in the same idle cycle: that tick does not align.
        addv(3,   1, 1, 0, 3,   3, 1, 0, 0, 0);
        addv(5,   1, 0, 0, 0,   3, 1, 1, 0, 0);
        addv(2,   0, 1, 1, 9,   0, 0, 0, 0, 0);
        // Abort on the final tick suppresses done.
        addv(3,   0, 1, 0, 1,   1, 1, 0, 0, 0);
        addv(5,   1, 0, 0, 0,   1, 1, 1, 0, 0);
        addv(5,   1, 0, 1, 0,   0, 0, 0, 0, 0);
        addv(0,   0, 0, 0, 0,   0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            wait_cycles(vecs[i].gap);
            set_tick(vecs[i].tk);
            bus.start    = vecs[i].start;
            bus.abort    = vecs[i].abort;
            bus.load_val = vecs[i].load;
            step();
            chk_all($sformatf("v%0d", i), vecs[i].e_remain, vecs[i].e_busy,
                    vecs[i].e_warn, vecs[i].e_blink, vecs[i].e_done);
            chk($sformatf("v%0d seq_err", i), int'(bus.seq_err), 0);
        end

        // Async reset mid-countdown clears outputs at once, no done afterwards.
        bus.load_val = 8'd5;
        bus.start    = 1'b1;
        step();
        apply_tick(1);
        apply_tick(1);
        chk("pre_reset remain", int'(bus.remain), 4);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.done || bus.busy) done_seen = 1'b1;
        end
        chk("post_reset activity", int'(done_seen), 0);

        // Tick parity: odd, even, odd, odd, then five correct ticks.
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        wait_cycles(2);
        begin
            int seq_tk[9];
            int seq_exp[9];
            seq_tk  = '{2, 3, 2, 2, 3, 2, 3, 2, 3};
            seq_exp = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
            for (int i = 0; i < 9; i++) begin
                wait_cycles(3);
                apply_tick(seq_tk[i]);
                chk($sformatf("seq%0d seq_err", i), int'(bus.seq_err), SEQ_ON ? seq_exp[i] : 0);
            end
        end

        // Both strobes in one cycle count as a single tick.
        bus.load_val = 8'd3;
        bus.start    = 1'b1;
        step();
        wait_cycles(2);
        apply_tick(4);
        chk_all("both_align", 3, 1, 1, 0, 0);
        wait_cycles(2);
        apply_tick(4);
        chk_all("both_dec", 2, 1, 1, 1, 0);
        chk("both seq_err", int'(bus.seq_err), SEQ_ON ? 1 : 0);
        bus.abort = 1'b1;
        step();
        chk_all("both_abort", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
